spi_baud_generator: RTL and testbench

//  Serial-clock stage downstream of the APB register interface: consumes sppr/spr/cpol/cpha/spi_mode/spiswai/ss.

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_baud_divisor.sv | 37 +++
 rtl/spi_baud_generator.sv | 108 ++++++++++
 tb/tb_spi_baud_generator.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: operating-mode encodings, default divisor width,
// and the divisor value held while in reset.
package spi_pkg;

  typedef enum logic [1:0] {
    spi_run  = 2'b00,
    spi_wait = 2'b01,
    spi_stop = 2'b10
  } spi_mode_e;

  localparam int unsigned DIV_W_DEF     = 12;
  localparam int unsigned RESET_DIVISOR = 2;

endpackage

// File: rtl/spi_baud_divisor.sv
// Baud divisor calculation: divisor = (sppr+1) * 2^(spr+1), registered.
// The slave-side timing checker uses this same block.
module spi_baud_divisor
  import spi_pkg::*;
#(
  parameter int unsigned DIV_W  = DIV_W_DEF,
  parameter int unsigned SPPR_W = 3,
  parameter int unsigned SPR_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SPPR_W-1:0] sppr,
  input  logic [SPR_W-1:0]  spr,
  output logic [DIV_W-1:0]  divisor
);

  logic [DIV_W-1:0] base;
  logic [SPR_W:0]   shamt;
  logic [DIV_W-1:0] next_divisor;

  // Extra shift-amount bit keeps spr=max from wrapping to a shift of zero.
  always_comb begin
    base         = DIV_W'(sppr) + DIV_W'(1);
    shamt        = {1'b0, spr} + {{SPR_W{1'b0}}, 1'b1};
    next_divisor = base << shamt;
  end

  // Register the divisor so downstream logic sees one stable value per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divisor <= DIV_W'(RESET_DIVISOR);
    end else begin
      divisor <= next_divisor;
    end
  end

endmodule

// File: rtl/spi_baud_generator.sv
// SPI master serial-clock generator: SCLK plus sample/shift strobes aligned
// to SCLK edges, and the shared baud divisor.
// Optional byte-complete strobe enabled by defining SPI_BAUD_EDGE_CNT_EN.
module spi_baud_generator
  import spi_pkg::*;
#(
  parameter int unsigned DIV_W  = DIV_W_DEF,
  parameter int unsigned SPPR_W = 3,
  parameter int unsigned SPR_W  = 3
) (
  input  logic              PClk,
  input  logic              PRESETn,
  input  logic [1:0]        spi_mode,
  input  logic              spiswai,
  input  logic [SPPR_W-1:0] sppr,
  input  logic [SPR_W-1:0]  spr,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              ss,
  output logic              sclk,
  output logic [DIV_W-1:0]  baudratedivisor,
  output logic              sample_flag,
  output logic              shift_flag,
  output logic              byte_done
);

  logic [DIV_W-1:0] count;
  logic [DIV_W-1:0] half_m1;
  logic             en;
  logic             toggle;
  logic             leading;
  spi_mode_e        mode;

  spi_baud_divisor #(
    .DIV_W  (DIV_W),
    .SPPR_W (SPPR_W),
    .SPR_W  (SPR_W)
  ) u_divisor (
    .clk     (PClk),
    .rst_n   (PRESETn),
    .sppr    (sppr),
    .spr     (spr),
    .divisor (baudratedivisor)
  );

  // Enable and edge decode; >= rather than == so a divisor that shrinks
  // mid-run toggles on the next cycle instead of wrapping the counter.
  always_comb begin
    mode    = spi_mode_e'(spi_mode);
    en      = !ss && ((mode == spi_run) || ((mode == spi_wait) && !spiswai));
    half_m1 = (baudratedivisor >> 1) - DIV_W'(1);
    toggle  = (count >= half_m1);
    leading = (sclk == cpol);
  end

  // Half-period counter, SCLK toggle and registered edge strobes.
  always_ff @(posedge PClk or negedge PRESETn) begin
    if (!PRESETn) begin
      sclk        <= 1'b0;
      count       <= '0;
      sample_flag <= 1'b0;
      shift_flag  <= 1'b0;
    end else if (!en) begin
      sclk        <= cpol;
      count       <= '0;
      sample_flag <= 1'b0;
      shift_flag  <= 1'b0;
    end else if (toggle) begin
      sclk        <= ~sclk;
      count       <= '0;
      sample_flag <= leading ^ cpha;
      shift_flag  <= ~(leading ^ cpha);
    end else begin
      count       <= count + DIV_W'(1);
      sample_flag <= 1'b0;
      shift_flag  <= 1'b0;
    end
  end

`ifdef SPI_BAUD_EDGE_CNT_EN
  logic [4:0] edge_cnt;

  // Count SCLK edges; strobe byte_done on the 16th and restart.
  always_ff @(posedge PClk or negedge PRESETn) begin
    if (!PRESETn) begin
      edge_cnt  <= '0;
      byte_done <= 1'b0;
    end else if (!en) begin
      edge_cnt  <= '0;
      byte_done <= 1'b0;
    end else if (toggle) begin
      if (edge_cnt == 5'd15) begin
        edge_cnt  <= '0;
        byte_done <= 1'b1;
      end else begin
        edge_cnt  <= edge_cnt + 5'd1;
        byte_done <= 1'b0;
      end
    end else begin
      byte_done <= 1'b0;
    end
  end
`else
  // Byte-complete strobe not built in this configuration.
  always_comb byte_done = 1'b0;
`endif

endmodule

// File: tb/tb_spi_baud_generator.sv
// Scoreboard bench for spi_baud_generator: stimulus pushes hand-derived
// edge events, a negedge monitor pops and compares on every strobe.
module tb_spi_baud_generator;
  import spi_pkg::*;

  logic        PClk = 1'b0;
  logic        PRESETn;
  logic [1:0]  spi_mode;
  logic        spiswai;
  logic [2:0]  sppr;
  logic [2:0]  spr;
  logic        cpol;
  logic        cpha;
  logic        ss;
  logic        sclk;
  logic [11:0] baudratedivisor;
  logic        sample_flag;
  logic        shift_flag;
  logic        byte_done;

  spi_baud_generator #(
    .DIV_W  (12),
    .SPPR_W (3),
    .SPR_W  (3)
  ) dut (
    .PClk            (PClk),
    .PRESETn         (PRESETn),
    .spi_mode        (spi_mode),
    .spiswai         (spiswai),
    .sppr            (sppr),
    .spr             (spr),
    .cpol            (cpol),
    .cpha            (cpha),
    .ss              (ss),
    .sclk            (sclk),
    .baudratedivisor (baudratedivisor),
    .sample_flag     (sample_flag),
    .shift_flag      (shift_flag),
    .byte_done       (byte_done)
  );

  always #5 PClk = ~PClk;

  int cyc = 0;
  always @(posedge PClk) cyc <= cyc + 1;

  typedef struct {
    int   cyc;
    logic sclk;
    logic sample;
    logic shift;
    logic bd;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every strobe must match the next expected edge event.
  always @(negedge PClk) begin
    ev_t e;
    if (PRESETn === 1'b1 && (sample_flag || shift_flag || byte_done)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: cycle %0d sample=%b shift=%b byte_done=%b, required no strobe",
                 cyc, sample_flag, shift_flag, byte_done);
      end else begin
        e = exp_q.pop_front();
        check("edge_cycle", 32'(cyc), 32'(e.cyc));
        check("edge_sclk", 32'(sclk), 32'(e.sclk));
        check("edge_sample", 32'(sample_flag), 32'(e.sample));
        check("edge_shift", 32'(shift_flag), 32'(e.shift));
        check("edge_byte_done", 32'(byte_done), 32'(e.bd));
      end
    end
  end

  // Edge i (1-based) of a burst from idle: odd edges are leading.
  task automatic push_edges(input int k, input int half, input int first, input int n,
                            input logic pol, input logic pha);
    ev_t e;
    for (int i = 1; i <= n; i++) begin
      e.cyc    = k + half * (first + i - 1);
      e.sclk   = pol ^ ((i % 2) == 1);
      e.sample = ((i % 2) == 1) ^ pha;
      e.shift  = ((i % 2) == 0) ^ pha;
`ifdef SPI_BAUD_EDGE_CNT_EN
      e.bd     = ((i % 16) == 0);
`else
      e.bd     = 1'b0;
`endif
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_until(input int t);
    int guard;
    guard = 0;
    while (cyc < t && guard < 5000) begin
      @(posedge PClk);
      #1;
      guard++;
    end
  endtask

  task automatic drain(input string name);
    repeat (4) @(posedge PClk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected edges not seen, required 0 outstanding", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic configure(input logic [2:0] pp, input logic [2:0] p, input logic pol,
                           input logic pha, input logic [1:0] m, input logic swai);
    @(posedge PClk);
    #1;
    ss = 1'b1;
    sppr = pp; spr = p; cpol = pol; cpha = pha; spi_mode = m; spiswai = swai;
    repeat (3) @(posedge PClk);
    #1;
  endtask

  task automatic run_vec(input string name, input logic [2:0] pp, input logic [2:0] p,
                         input logic pol, input logic pha, input logic [1:0] m,
                         input logic swai, input int n, input int exp_div);
    int k;
    configure(pp, p, pol, pha, m, swai);
    check({name, "_divisor"}, 32'(baudratedivisor), 32'(exp_div));
    check({name, "_idle"}, 32'(sclk), 32'(pol));
    k = cyc;
    push_edges(k, exp_div / 2, 1, n, pol, pha);
    ss = 1'b0;
    wait_until(k + (exp_div / 2) * n);
    ss = 1'b1;
    drain({name, "_drain"});
  endtask

  initial begin
    int k;
    PRESETn = 1'b0;
    ss = 1'b1; spi_mode = 2'b00; spiswai = 1'b0;
    sppr = 3'd0; spr = 3'd0; cpol = 1'b0; cpha = 1'b0;
    repeat (3) @(posedge PClk);
    #1;
    check("reset_sclk", 32'(sclk), 32'd0);
    check("reset_divisor", 32'(baudratedivisor), 32'd2);
    check("reset_sample", 32'(sample_flag), 32'd0);
    check("reset_shift", 32'(shift_flag), 32'd0);
    check("reset_byte_done", 32'(byte_done), 32'd0);
    PRESETn = 1'b1;

    // Directed bursts: name, sppr, spr, cpol, cpha, mode, spiswai, edges, divisor.
    run_vec("div2",      3'd0, 3'd0, 1'b0, 1'b0, 2'b00, 1'b0, 32, 2);
    run_vec("div12",     3'd2, 3'd1, 1'b0, 1'b0, 2'b00, 1'b0, 16, 12);
    run_vec("div12_p1",  3'd2, 3'd1, 1'b1, 1'b1, 2'b00, 1'b0, 16, 12);
    run_vec("div4_h1",   3'd1, 3'd0, 1'b0, 1'b1, 2'b00, 1'b0, 8,  4);
    run_vec("wait_run",  3'd3, 3'd2, 1'b1, 1'b0, 2'b01, 1'b0, 8,  32);
    run_vec("div2048",   3'd7, 3'd7, 1'b0, 1'b0, 2'b00, 1'b0, 2,  2048);
    run_vec("div2_p1",   3'd0, 3'd0, 1'b1, 1'b1, 2'b00, 1'b0, 16, 2);

    // Divisor shrinks from 12 to 2 after two counts: old half still governs the
    // next compare, then count 3 >= 0 toggles at k+4 and every cycle after.
    configure(3'd2, 3'd1, 1'b0, 1'b0, 2'b00, 1'b0);
    k = cyc;
    push_edges(k, 1, 4, 4, 1'b0, 1'b0);
    ss = 1'b0;
    wait_until(k + 2);
    sppr = 3'd0; spr = 3'd0;
    wait_until(k + 7);
    ss = 1'b1;
    drain("shrink_drain");

    // Run -> wait with spiswai=1 after three edges (sclk high): aborts to idle.
    configure(3'd2, 3'd1, 1'b0, 1'b0, 2'b00, 1'b0);
    k = cyc;
    push_edges(k, 6, 1, 3, 1'b0, 1'b0);
    ss = 1'b0;
    wait_until(k + 20);
    check("pre_abort_sclk", 32'(sclk), 32'd1);
    spi_mode = 2'b01; spiswai = 1'b1;
    @(posedge PClk);
    @(negedge PClk);
    check("abort_sclk", 32'(sclk), 32'd0);
    check("abort_sample", 32'(sample_flag), 32'd0);
    check("abort_shift", 32'(shift_flag), 32'd0);
    repeat (20) @(posedge PClk);
    #1;
    ss = 1'b1; spi_mode = 2'b00; spiswai = 1'b0;
    drain("abort_drain");

    // Stop mode never enables: SCLK holds idle level.
    configure(3'd0, 3'd0, 1'b1, 1'b0, 2'b10, 1'b0);
    ss = 1'b0;
    repeat (40) @(posedge PClk);
    #1;
    check("stop_sclk", 32'(sclk), 32'd1);
    ss = 1'b1; spi_mode = 2'b00;
    drain("stop_drain");

    // Asynchronous reset mid-transfer, sampled before any further clock edge.
    configure(3'd2, 3'd1, 1'b0, 1'b1, 2'b00, 1'b0);
    k = cyc;
    push_edges(k, 6, 1, 3, 1'b0, 1'b1);
    ss = 1'b0;
    wait_until(k + 20);
    check("pre_reset_sclk", 32'(sclk), 32'd1);
    #2 PRESETn = 1'b0;
    #1;
    check("async_rst_sclk", 32'(sclk), 32'd0);
    check("async_rst_divisor", 32'(baudratedivisor), 32'd2);
    check("async_rst_sample", 32'(sample_flag), 32'd0);
    check("async_rst_shift", 32'(shift_flag), 32'd0);
    ss = 1'b1;
    repeat (2) @(posedge PClk);
    #1;
    PRESETn = 1'b1;
    repeat (2) @(posedge PClk);
    #1;
    check("post_reset_divisor", 32'(baudratedivisor), 32'd12);
    drain("reset_drain");

    // Partial byte then ss high: edge count restarts for the next burst.
    configure(3'd0, 3'd0, 1'b0, 1'b0, 2'b00, 1'b0);
    k = cyc;
    push_edges(k, 1, 1, 8, 1'b0, 1'b0);
    ss = 1'b0;
    wait_until(k + 8);
    ss = 1'b1;
    drain("partial_drain");
    run_vec("after_partial", 3'd0, 3'd0, 1'b0, 1'b0, 2'b00, 1'b0, 16, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before completion, required finish");
    $fatal(1);
  end

endmodule
